// File: rtl/clock_step_ctrl.sv
// clock_step_ctrl: processor clock-enable generator.
// Produces a one-cycle tick at a 2^i rate (RUN), one tick per debounced
// button press (STEP), or nothing (HALT). Everything runs on CLK_in.
module clock_step_ctrl #(
    parameter int SIZE    = 36,
    parameter int DB_BITS = 20
) (
    input  logic        CLK_in,
    input  logic        RST,
    input  logic [1:0]  mode,
    input  logic [5:0]  rate_sel,
    input  logic        step_btn,
    output logic        tick,
    output logic [1:0]  state,
    output logic [15:0] tick_cnt
);

    typedef enum logic [1:0] {
        S_HALT  = 2'b00,
        S_RUN   = 2'b01,
        S_ARMED = 2'b10,
        S_HELD  = 2'b11
    } state_t;

    localparam logic [1:0] M_RUN  = 2'b01;
    localparam logic [1:0] M_STEP = 2'b10;
    localparam logic [5:0] SIZE_I = 6'(SIZE);

    state_t              st, st_n;
    logic [SIZE-1:0]     div_c;
    logic [SIZE-1:0]     mask;
    logic [5:0]          rate_cl, rate_q;
    logic                rate_chg, rc;
    logic                sync1, sync2, db, db_q;
    logic [DB_BITS-1:0]  db_cnt;
    logic                press, rel, tick_n;

    assign state    = st;
    assign rate_cl  = (rate_sel > SIZE_I) ? SIZE_I : rate_sel;
    assign rate_chg = (rate_cl != rate_q);
    assign press    = db & ~db_q;
    assign rel      = ~db & db_q;

    // Rate condition: low i bits of the divider all ones (i==0 gives an empty mask).
    always_comb begin
        mask = '0;
        for (int k = 0; k < SIZE; k++)
            mask[k] = (k < int'(rate_q));
        rc = (&(div_c | ~mask)) && !rate_chg;
    end

    // Divider restarts from 0 on a rate change so the new period starts clean.
    always_ff @(posedge CLK_in or posedge RST) begin
        if (RST) begin
            div_c  <= '0;
            rate_q <= '0;
        end else begin
            rate_q <= rate_cl;
            div_c  <= rate_chg ? '0 : div_c + SIZE'(1);
        end
    end

    // Two-flop synchronizer for the raw button.
    always_ff @(posedge CLK_in or posedge RST) begin
        if (RST) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= step_btn;
            sync2 <= sync1;
        end
    end

    // Debouncer: db follows sync2 only after 2^DB_BITS consecutive disagreeing samples.
    always_ff @(posedge CLK_in or posedge RST) begin
        if (RST) begin
            db     <= 1'b0;
            db_q   <= 1'b0;
            db_cnt <= '0;
        end else begin
            db_q <= db;
            if (sync2 == db) begin
                db_cnt <= '0;
            end else if (&db_cnt) begin
                db     <= sync2;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DB_BITS'(1);
            end
        end
    end

    // Next state and next tick; mode always takes priority over button events.
    always_comb begin
        st_n   = st;
        tick_n = 1'b0;
        case (mode)
            M_RUN:  st_n = S_RUN;
            M_STEP: begin
                case (st)
                    S_HALT, S_RUN: st_n = db ? S_HELD : S_ARMED;
                    S_ARMED:       if (press) st_n = S_HELD;
                    S_HELD:        if (rel)   st_n = S_ARMED;
                    default:       st_n = S_HALT;
                endcase
            end
            default: st_n = S_HALT;
        endcase
        tick_n = (st == S_RUN   && mode == M_RUN  && rc) ||
                 (st == S_ARMED && mode == M_STEP && press);
    end

    // State, tick and tick counter registers.
    always_ff @(posedge CLK_in or posedge RST) begin
        if (RST) begin
            st       <= S_HALT;
            tick     <= 1'b0;
            tick_cnt <= '0;
        end else begin
            st   <= st_n;
            tick <= tick_n;
            if (tick_n)
                tick_cnt <= tick_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_clock_step_ctrl.sv
// Directed bench for clock_step_ctrl: expected tick edges and counts are
// queued when stimulus is applied and checked as each tick appears.
module tb_clock_step_ctrl;

    logic        CLK_in = 1'b0;
    logic        RST;
    logic [1:0]  mode;
    logic [5:0]  rate_sel;
    logic        step_btn;
    logic        tick;
    logic [1:0]  state;
    logic [15:0] tick_cnt;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc   = 0;
    int          exp_q[$];
    logic [15:0] cnt_q[$];
    logic [15:0] exp_cnt;

    clock_step_ctrl #(.SIZE(36), .DB_BITS(3)) dut (
        .CLK_in   (CLK_in),
        .RST      (RST),
        .mode     (mode),
        .rate_sel (rate_sel),
        .step_btn (step_btn),
        .tick     (tick),
        .state    (state),
        .tick_cnt (tick_cnt)
    );

    always #5 CLK_in = ~CLK_in;

    // Edge number: after rising edge E, cyc == E.
    always @(posedge CLK_in) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expect a tick set by rising edge e, carrying the next count value.
    task automatic tick_at(input int e);
        exp_cnt = exp_cnt + 16'd1;
        exp_q.push_back(e);
        cnt_q.push_back(exp_cnt);
    endtask

    task automatic adv(input int n);
        repeat (n) @(posedge CLK_in);
        #1;
    endtask

    // Scoreboard: every observed tick must match the head of the queue.
    always @(negedge CLK_in) begin
        if (RST === 1'b0 && tick === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_tick_edge", 64'(cyc), 64'hFFFF_FFFF);
            end else begin
                chk("tick_edge", 64'(cyc), 64'(exp_q.pop_front()));
                chk("tick_cnt", 64'(tick_cnt), 64'(cnt_q.pop_front()));
            end
        end
    end

    initial begin
        int b;
        int n;
        RST = 1'b1; mode = 2'b00; rate_sel = 6'd0; step_btn = 1'b0;
        exp_cnt = 16'd0;
        adv(3);
        chk("rst_tick", 64'(tick), 64'd0);
        chk("rst_state", 64'(state), 64'd0);
        chk("rst_cnt", 64'(tick_cnt), 64'd0);

        // Reset mid-RUN at i=3; first release edge is the rate-change edge.
        RST = 1'b0; mode = 2'b01; rate_sel = 6'd3; b = cyc;
        tick_at(b + 9); tick_at(b + 17);
        adv(25);
        chk("inflight_tick", 64'(tick), 64'd1);
        RST = 1'b1; #1;
        chk("async_rst_tick", 64'(tick), 64'd0);
        chk("async_rst_state", 64'(state), 64'd0);
        chk("async_rst_cnt", 64'(tick_cnt), 64'd0);
        chk("q_empty_rst", 64'(exp_q.size()), 64'd0);
        exp_cnt = 16'd0;
        adv(2);
        RST = 1'b0; b = cyc;
        tick_at(b + 9); tick_at(b + 17);
        adv(18);

        // RUN at i=0, then i=2.
        rate_sel = 6'd0; b = cyc;
        for (int k = 2; k <= 11; k++) tick_at(b + k);
        adv(11);
        rate_sel = 6'd2; b = cyc;
        tick_at(b + 5); tick_at(b + 9); tick_at(b + 13);
        adv(14);
        chk("cnt_after_rates", 64'(tick_cnt), 64'(exp_cnt));

        // Halt, reserved mode, then back to RUN with phase preserved.
        rate_sel = 6'd1; b = cyc;
        tick_at(b + 3); tick_at(b + 5); tick_at(b + 7);
        adv(8);
        mode = 2'b00;
        adv(1);
        chk("halt_state", 64'(state), 64'd0);
        adv(1);
        mode = 2'b11;
        adv(8);
        chk("mode11_state", 64'(state), 64'd0);
        adv(2);
        mode = 2'b01;
        tick_at(b + 23); tick_at(b + 25);
        adv(5);

        // Enter STEP with the button already held.
        mode = 2'b00; step_btn = 1'b1;
        adv(12);
        rate_sel = 6'd5; mode = 2'b01;
        adv(2);
        mode = 2'b10;
        adv(1);
        chk("held_entry_state", 64'(state), 64'd3);
        adv(10);
        chk("held_stay_state", 64'(state), 64'd3);
        step_btn = 1'b0;
        adv(15);
        chk("armed_after_rel", 64'(state), 64'd2);
        step_btn = 1'b1; b = cyc;
        tick_at(b + 11);
        adv(11);
        chk("held_after_press", 64'(state), 64'd3);
        adv(5);
        step_btn = 1'b0;
        adv(15);
        chk("armed_again", 64'(state), 64'd2);

        // Bounce shorter than the debounce window, then a clean hold.
        for (int k = 0; k < 2; k++) begin
            step_btn = 1'b1; adv(5);
            step_btn = 1'b0; adv(5);
            chk("bounce_state", 64'(state), 64'd2);
        end
        step_btn = 1'b1; b = cyc;
        tick_at(b + 11);
        adv(20);
        chk("bounce_held", 64'(state), 64'd3);
        step_btn = 1'b0;
        adv(20);
        chk("bounce_armed", 64'(state), 64'd2);
        chk("cnt_after_step", 64'(tick_cnt), 64'(exp_cnt));

        // Clamp: 63 -> 36, no tick for 1000 cycles.
        mode = 2'b01; rate_sel = 6'd63;
        adv(1000);
        chk("clamp_cnt", 64'(tick_cnt), 64'(exp_cnt));

        // Counter wrap at i=0.
        rate_sel = 6'd0; b = cyc;
        n = 65536 - int'(exp_cnt);
        for (int k = 0; k < n; k++) tick_at(b + 2 + k);
        adv(1 + n);
        mode = 2'b00;
        adv(2);
        chk("wrap_cnt", 64'(tick_cnt), 64'd0);
        chk("wrap_tick_off", 64'(tick), 64'd0);
        chk("q_empty_end", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
